// File: rtl/pe_dbuf_pkg.sv
// Purpose : shared defaults and types for the double-buffered systolic PE.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
// Contents: default DATA_W/ACC_W, weight-buffer state enum, saturation-limit helpers.
package pe_dbuf_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 24;

  // Shadow weight register occupancy.
  typedef enum logic {
    WB_EMPTY  = 1'b0,
    WB_LOADED = 1'b1
  } wbuf_state_t;

  // Saturation limits for an ACC_W-bit accumulator, returned right-aligned
  // in 64 bits; callers truncate to their own width.
  function automatic logic [63:0] sat_max(input int acc_w, input bit is_signed);
    logic [63:0] ones;
    ones = '1;
    if (is_signed) return ones >> (65 - acc_w);
    else           return ones >> (64 - acc_w);
  endfunction

  function automatic logic [63:0] sat_min(input int acc_w, input bit is_signed);
    logic [63:0] one;
    one = 64'd1;
    if (is_signed) return one << (acc_w - 1);
    else           return '0;
  endfunction

endpackage

// File: rtl/pe_dbuf_mac.sv
// Purpose : combinational multiply-accumulate with overflow detect and optional clamp.
// Latency : 0 cycles (purely combinational).
// Backpressure : none; result is consumed or ignored by the registering parent.
// Ports: a/w (DATA_W operands), psum (ACC_W addend) -> sum (ACC_W), ovf (overflow of psum + a*w).
module pe_mac
  import pe_dbuf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] w,
  input  logic [ACC_W-1:0]  psum,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam int PW = 2 * DATA_W;

  localparam logic [63:0]      SMAX64 = sat_max(ACC_W, 1'b1);
  localparam logic [63:0]      SMIN64 = sat_min(ACC_W, 1'b1);
  localparam logic [63:0]      UMAX64 = sat_max(ACC_W, 1'b0);
  localparam logic [ACC_W-1:0] SMAX   = SMAX64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] SMIN   = SMIN64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] UMAX   = UMAX64[ACC_W-1:0];

  logic [PW-1:0]    a_x;
  logic [PW-1:0]    w_x;
  logic [PW-1:0]    prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   raw;
  logic [ACC_W-1:0] lim;

  always_comb begin
    // Extend operands to the full product width first; the low PW bits of
    // the product are then correct for both signed and unsigned operands.
    if (SIGNED != 0) begin
      a_x = {{DATA_W{a[DATA_W-1]}}, a};
      w_x = {{DATA_W{w[DATA_W-1]}}, w};
    end else begin
      a_x = {{DATA_W{1'b0}}, a};
      w_x = {{DATA_W{1'b0}}, w};
    end
    prod = a_x * w_x;

    if (SIGNED != 0) prod_ext = ACC_W'($signed(prod));
    else             prod_ext = ACC_W'(prod);

    raw = {1'b0, psum} + {1'b0, prod_ext};

    if (SIGNED != 0) begin
      ovf = (psum[ACC_W-1] == prod_ext[ACC_W-1]) && (raw[ACC_W-1] != psum[ACC_W-1]);
      // Both operands share a sign on overflow, so psum's sign picks the rail.
      lim = psum[ACC_W-1] ? SMIN : SMAX;
    end else begin
      ovf = raw[ACC_W];
      lim = UMAX;
    end

    if ((SATURATE != 0) && ovf) sum = lim;
    else                        sum = raw[ACC_W-1:0];
  end

endmodule

// File: rtl/pe_dbuf.sv
// Purpose : systolic PE with double-buffered weight (shadow shift chain + active), MAC, sticky overflow.
// Latency : 1 cycle input->output for data, partial sum, valids; weight chain 1 cycle per hop.
// Backpressure : en=0 holds all datapath outputs; weight shift/swap keep working during a stall.
// Ports: clk, rst_n; en; in_left/in_left_vld -> out_right/out_right_vld; in_up -> out_down/out_down_vld;
//        w_in/w_shift -> w_out; w_swap, w_ready; ovf/ovf_clr.
module pe_dbuf
  import pe_dbuf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] in_left,
  input  logic              in_left_vld,
  input  logic [ACC_W-1:0]  in_up,
  output logic [DATA_W-1:0] out_right,
  output logic              out_right_vld,
  output logic [ACC_W-1:0]  out_down,
  output logic              out_down_vld,
  input  logic [DATA_W-1:0] w_in,
  input  logic              w_shift,
  output logic [DATA_W-1:0] w_out,
  input  logic              w_swap,
  output logic              w_ready,
  output logic              ovf,
  input  logic              ovf_clr
);

  // ---------------- weight double buffer ----------------
  wbuf_state_t       wstate, wstate_nxt;
  logic [DATA_W-1:0] active, active_nxt;
  logic [DATA_W-1:0] shadow, shadow_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate <= WB_EMPTY;
      active <= '0;
      shadow <= '0;
    end else begin
      wstate <= wstate_nxt;
      active <= active_nxt;
      shadow <= shadow_nxt;
    end
  end

  always_comb begin
    wstate_nxt = wstate;
    active_nxt = active;
    shadow_nxt = shadow;
    if (w_shift) shadow_nxt = w_in;
    case (wstate)
      WB_EMPTY: begin
        // A swap with nothing buffered is dropped.
        if (w_shift) wstate_nxt = WB_LOADED;
      end
      WB_LOADED: begin
        if (w_swap) begin
          // Old shadow moves to active even if a new weight shifts in now.
          active_nxt = shadow;
          if (!w_shift) wstate_nxt = WB_EMPTY;
        end
      end
      default: wstate_nxt = WB_EMPTY;
    endcase
  end

  assign w_out   = shadow;
  assign w_ready = (wstate == WB_LOADED);

  // ---------------- datapath ----------------
  logic [ACC_W-1:0] mac_sum;
  logic             mac_ovf;

  // Uses the registered active weight, so a swap takes effect one edge later.
  pe_mac #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_mac (
    .a    (in_left),
    .w    (active),
    .psum (in_up),
    .sum  (mac_sum),
    .ovf  (mac_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_right     <= '0;
      out_right_vld <= 1'b0;
      out_down      <= '0;
      out_down_vld  <= 1'b0;
    end else if (en) begin
      if (in_left_vld) begin
        out_right     <= in_left;
        out_right_vld <= 1'b1;
        out_down      <= mac_sum;
        out_down_vld  <= 1'b1;
      end else begin
        // Invalid slot becomes a zero bubble rather than stale data.
        out_right     <= '0;
        out_right_vld <= 1'b0;
        out_down      <= '0;
        out_down_vld  <= 1'b0;
      end
    end
  end

  // Sticky overflow; clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              ovf <= 1'b0;
    else if (ovf_clr)                        ovf <= 1'b0;
    else if (en && in_left_vld && mac_ovf)   ovf <= 1'b1;
  end

endmodule

// File: tb/tb_pe_dbuf.sv
module tb_pe_dbuf;

  logic        clk = 1'b0;
  logic        rst_n, en, in_left_vld, w_shift, w_swap, ovf_clr;
  logic [7:0]  in_left, w_in;
  logic [23:0] in_up;

  logic [7:0]  o_r   [4];
  logic        o_rv  [4];
  logic        o_dv  [4];
  logic        w_rdy [4];
  logic        ovf_o [4];
  logic [7:0]  w_o   [4];
  logic [23:0] od0;
  logic [15:0] od1, od2, od3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // 0: default signed 8/24 saturating; 1: signed 8/16 sat; 2: signed 8/16 wrap; 3: unsigned 8/16 sat
  pe_dbuf #(.DATA_W(8), .ACC_W(24), .SIGNED(1), .SATURATE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_left(in_left), .in_left_vld(in_left_vld),
    .in_up(in_up), .out_right(o_r[0]), .out_right_vld(o_rv[0]), .out_down(od0),
    .out_down_vld(o_dv[0]), .w_in(w_in), .w_shift(w_shift), .w_out(w_o[0]),
    .w_swap(w_swap), .w_ready(w_rdy[0]), .ovf(ovf_o[0]), .ovf_clr(ovf_clr));
  pe_dbuf #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_left(in_left), .in_left_vld(in_left_vld),
    .in_up(in_up[15:0]), .out_right(o_r[1]), .out_right_vld(o_rv[1]), .out_down(od1),
    .out_down_vld(o_dv[1]), .w_in(w_in), .w_shift(w_shift), .w_out(w_o[1]),
    .w_swap(w_swap), .w_ready(w_rdy[1]), .ovf(ovf_o[1]), .ovf_clr(ovf_clr));
  pe_dbuf #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_left(in_left), .in_left_vld(in_left_vld),
    .in_up(in_up[15:0]), .out_right(o_r[2]), .out_right_vld(o_rv[2]), .out_down(od2),
    .out_down_vld(o_dv[2]), .w_in(w_in), .w_shift(w_shift), .w_out(w_o[2]),
    .w_swap(w_swap), .w_ready(w_rdy[2]), .ovf(ovf_o[2]), .ovf_clr(ovf_clr));
  pe_dbuf #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(1)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_left(in_left), .in_left_vld(in_left_vld),
    .in_up(in_up[15:0]), .out_right(o_r[3]), .out_right_vld(o_rv[3]), .out_down(od3),
    .out_down_vld(o_dv[3]), .w_in(w_in), .w_shift(w_shift), .w_out(w_o[3]),
    .w_swap(w_swap), .w_ready(w_rdy[3]), .ovf(ovf_o[3]), .ovf_clr(ovf_clr));

  // ---------------- reference model ----------------
  longint m_active, m_shadow, m_right;
  bit     m_loaded, m_vld;
  longint m_down [4];
  bit     m_ovf  [4];

  function automatic int acc_w(input int k);
    return (k == 0) ? 24 : 16;
  endfunction
  function automatic bit is_signed(input int k);
    return k != 3;
  endfunction
  function automatic bit saturates(input int k);
    return k != 2;
  endfunction
  function automatic longint mask_of(input int k);
    return (longint'(1) << acc_w(k)) - 1;
  endfunction

  // Exact integer sum, then range check against the accumulator's value range.
  function automatic longint mac_ref(input int k, input longint a_b, input longint w_b,
                                     input longint up_b, output bit ov);
    longint a, w, up, s, lo, hi, res;
    int n;
    n = acc_w(k);
    a = a_b; w = w_b; up = up_b;
    if (is_signed(k)) begin
      if (a >= 128) a -= 256;
      if (w >= 128) w -= 256;
      if (up >= (longint'(1) << (n - 1))) up -= (longint'(1) << n);
      hi = (longint'(1) << (n - 1)) - 1;
      lo = -(longint'(1) << (n - 1));
    end else begin
      hi = (longint'(1) << n) - 1;
      lo = 0;
    end
    s  = up + a * w;
    ov = (s > hi) || (s < lo);
    res = s;
    if (ov && saturates(k)) res = (s > hi) ? hi : lo;
    return res & mask_of(k);
  endfunction

  function automatic longint obs_down(input int k);
    case (k)
      0:       return longint'(od0);
      1:       return longint'(od1);
      2:       return longint'(od2);
      default: return longint'(od3);
    endcase
  endfunction

  task automatic model_reset();
    m_active = 0; m_shadow = 0; m_right = 0; m_loaded = 0; m_vld = 0;
    for (int k = 0; k < 4; k++) begin m_down[k] = 0; m_ovf[k] = 0; end
  endtask

  // Advance one clock; model next state is computed from pre-edge inputs.
  task automatic tick();
    longint nd [4];
    bit     nov [4];
    bit     o;
    longint nr, na, ns;
    bit     nv, nl;
    nr = m_right; nv = m_vld;
    for (int k = 0; k < 4; k++) begin nd[k] = m_down[k]; nov[k] = m_ovf[k]; end
    if (en) begin
      if (in_left_vld) begin
        nr = longint'(in_left); nv = 1;
        for (int k = 0; k < 4; k++) begin
          nd[k] = mac_ref(k, longint'(in_left), m_active, longint'(in_up) & mask_of(k), o);
          if (o) nov[k] = 1;
        end
      end else begin
        nr = 0; nv = 0;
        for (int k = 0; k < 4; k++) nd[k] = 0;
      end
    end
    if (ovf_clr) for (int k = 0; k < 4; k++) nov[k] = 0;
    na = (w_swap && m_loaded) ? m_shadow : m_active;
    ns = w_shift ? longint'(w_in) : m_shadow;
    nl = w_shift || (m_loaded && !w_swap);
    @(posedge clk);
    #1;
    m_right = nr; m_vld = nv; m_active = na; m_shadow = ns; m_loaded = nl;
    for (int k = 0; k < 4; k++) begin m_down[k] = nd[k]; m_ovf[k] = nov[k]; end
  endtask

  task automatic idle_inputs();
    en = 1; in_left = 0; in_left_vld = 0; in_up = 0;
    w_in = 0; w_shift = 0; w_swap = 0; ovf_clr = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0; idle_inputs(); model_reset();
    #12;
    for (int k = 0; k < 4; k++) begin
      checks++; if (o_r[k] !== 8'd0 || o_rv[k] !== 1'b0 || o_dv[k] !== 1'b0) begin
        errors++; $display("FAIL reset_right[%0d]: got %0d/%0b/%0b want 0/0/0", k, o_r[k], o_rv[k], o_dv[k]); end
      checks++; if (obs_down(k) !== 64'd0) begin
        errors++; $display("FAIL reset_down[%0d]: got %0d want 0", k, obs_down(k)); end
      checks++; if (w_o[k] !== 8'd0 || w_rdy[k] !== 1'b0 || ovf_o[k] !== 1'b0) begin
        errors++; $display("FAIL reset_weight[%0d]: got w_out=%0d rdy=%0b ovf=%0b want 0", k, w_o[k], w_rdy[k], ovf_o[k]); end
    end
    rst_n = 1;
  endtask

  task automatic test_basic_mac();
    w_in = 8'd3; w_shift = 1; tick(); w_shift = 0;
    checks++; if (w_rdy[0] !== 1'b1 || w_o[0] !== 8'd3) begin
      errors++; $display("FAIL basic_load: got rdy=%0b w_out=%0d want 1/3", w_rdy[0], w_o[0]); end
    w_swap = 1; tick(); w_swap = 0;
    checks++; if (w_rdy[0] !== 1'b0) begin
      errors++; $display("FAIL basic_swap_rdy: got %0b want 0", w_rdy[0]); end
    in_left = 8'd5; in_left_vld = 1; in_up = 24'd10; tick();
    checks++; if (od0 !== 24'd25 || od1 !== 16'd25) begin
      errors++; $display("FAIL basic_down: got %0d/%0d want 25/25", od0, od1); end
    checks++; if (o_r[0] !== 8'd5 || o_rv[0] !== 1'b1 || o_dv[0] !== 1'b1) begin
      errors++; $display("FAIL basic_right: got %0d/%0b/%0b want 5/1/1", o_r[0], o_rv[0], o_dv[0]); end
  endtask

  task automatic test_swap_overlap();
    in_left_vld = 0; w_in = 8'd7; w_shift = 1; tick(); w_shift = 0;
    w_swap = 1; in_left = 8'd2; in_left_vld = 1; in_up = 24'd0; tick(); w_swap = 0;
    checks++; if (od0 !== 24'd6) begin
      errors++; $display("FAIL overlap_old_weight: got %0d want 6", od0); end
    tick();
    checks++; if (od0 !== 24'd14) begin
      errors++; $display("FAIL overlap_new_weight: got %0d want 14", od0); end
  endtask

  task automatic test_stall();
    en = 0; w_in = 8'd9; w_shift = 1;
    for (int i = 0; i < 3; i++) begin
      in_left = 8'($urandom); in_up = 24'($urandom); in_left_vld = 1'($urandom);
      tick(); w_shift = 0;
      checks++; if (od0 !== 24'd14 || o_r[0] !== 8'd2 || o_rv[0] !== 1'b1 || o_dv[0] !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d]: got down=%0d right=%0d vld=%0b%0b want 14/2/11", i, od0, o_r[0], o_rv[0], o_dv[0]); end
    end
    checks++; if (w_rdy[0] !== 1'b1 || w_o[0] !== 8'd9) begin
      errors++; $display("FAIL stall_shift: got rdy=%0b w_out=%0d want 1/9", w_rdy[0], w_o[0]); end
    en = 1; in_left_vld = 0;
  endtask

  task automatic test_overflow();
    w_in = 8'd127; w_shift = 1; tick(); w_shift = 0;
    w_swap = 1; tick(); w_swap = 0;
    in_left = 8'd127; in_up = 24'h007FFF; in_left_vld = 1; tick();
    checks++; if (od1 !== 16'h7FFF || ovf_o[1] !== 1'b1) begin
      errors++; $display("FAIL ovf_sat: got %0h ovf=%0b want 7fff/1", od1, ovf_o[1]); end
    checks++; if (od2 !== 16'hBF00 || ovf_o[2] !== 1'b1) begin
      errors++; $display("FAIL ovf_wrap: got %0h ovf=%0b want bf00/1", od2, ovf_o[2]); end
    checks++; if (od0 !== 24'h00BF00 || ovf_o[0] !== 1'b0) begin
      errors++; $display("FAIL ovf_wide: got %0h ovf=%0b want 00bf00/0", od0, ovf_o[0]); end
    checks++; if (od3 !== 16'hBF00 || ovf_o[3] !== 1'b0) begin
      errors++; $display("FAIL ovf_unsigned: got %0h ovf=%0b want bf00/0", od3, ovf_o[3]); end
    in_left_vld = 0; tick();
    checks++; if (ovf_o[1] !== 1'b1 || od1 !== 16'd0 || o_dv[1] !== 1'b0) begin
      errors++; $display("FAIL ovf_sticky: got ovf=%0b down=%0h vld=%0b want 1/0/0", ovf_o[1], od1, o_dv[1]); end
    in_left_vld = 1; ovf_clr = 1; tick(); ovf_clr = 0;
    checks++; if (ovf_o[1] !== 1'b0 || ovf_o[2] !== 1'b0 || od1 !== 16'h7FFF) begin
      errors++; $display("FAIL ovf_clr_prio: got ovf=%0b%0b down=%0h want 00/7fff", ovf_o[1], ovf_o[2], od1); end
    in_left_vld = 0;
  endtask

  task automatic test_unsigned();
    w_in = 8'd255; w_shift = 1; tick(); w_shift = 0;
    w_swap = 1; tick(); w_swap = 0;
    in_left = 8'd255; in_up = 24'd0; in_left_vld = 1; tick();
    checks++; if (od3 !== 16'd65025 || ovf_o[3] !== 1'b0) begin
      errors++; $display("FAIL unsigned_max: got %0d ovf=%0b want 65025/0", od3, ovf_o[3]); end
    checks++; if (od1 !== 16'd1) begin
      errors++; $display("FAIL signed_neg1sq: got %0d want 1", od1); end
    in_left_vld = 0; tick();
    checks++; if (od3 !== 16'd0 || o_dv[3] !== 1'b0 || o_rv[3] !== 1'b0) begin
      errors++; $display("FAIL bubble: got %0d vld=%0b%0b want 0/00", od3, o_rv[3], o_dv[3]); end
  endtask

  task automatic test_swap_empty();
    w_swap = 1; in_left = 8'd1; in_up = 24'd0; in_left_vld = 1; tick(); w_swap = 0;
    tick();
    checks++; if (od3 !== 16'd255 || od1 !== 16'hFFFF || w_rdy[3] !== 1'b0) begin
      errors++; $display("FAIL swap_empty: got %0d/%0h rdy=%0b want 255/ffff/0", od3, od1, w_rdy[3]); end
    in_left_vld = 0;
  endtask

  task automatic test_async_reset();
    w_in = 8'd5; w_shift = 1; in_left = 8'd3; in_up = 24'd4; in_left_vld = 1; tick();
    w_shift = 0;
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (o_r[k] !== 8'd0 || o_rv[k] !== 1'b0 || o_dv[k] !== 1'b0 || obs_down(k) !== 64'd0) begin
        errors++; $display("FAIL async_rst_data[%0d]: got %0d/%0b/%0b/%0d want 0", k, o_r[k], o_rv[k], o_dv[k], obs_down(k)); end
      checks++; if (w_o[k] !== 8'd0 || w_rdy[k] !== 1'b0) begin
        errors++; $display("FAIL async_rst_weight[%0d]: got %0d/%0b want 0/0", k, w_o[k], w_rdy[k]); end
    end
    model_reset(); idle_inputs();
    @(posedge clk); #1;
    rst_n = 1;
    // Active weight was discarded too: a valid MAC now returns in_up alone.
    in_left = 8'd9; in_up = 24'd33; in_left_vld = 1; tick();
    checks++; if (od0 !== 24'd33) begin
      errors++; $display("FAIL async_rst_active: got %0d want 33", od0); end
    in_left_vld = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en          = ($urandom_range(0, 3) != 0);
      in_left_vld = 1'($urandom);
      in_left     = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       in_up = 24'h007FFF;
        1:       in_up = 24'hFF8000;
        default: in_up = 24'($urandom);
      endcase
      w_in    = 8'($urandom);
      w_shift = ($urandom_range(0, 9) < 3);
      w_swap  = ($urandom_range(0, 9) < 2);
      ovf_clr = en && ($urandom_range(0, 19) == 0);
      tick();
      for (int k = 0; k < 4; k++) begin
        checks++; if (obs_down(k) !== m_down[k] || o_dv[k] !== m_vld) begin
          errors++; $display("FAIL rand_down[%0d] cyc %0d: got %0h/%0b want %0h/%0b", k, i, obs_down(k), o_dv[k], m_down[k], m_vld); end
        checks++; if (longint'(o_r[k]) !== m_right || o_rv[k] !== m_vld) begin
          errors++; $display("FAIL rand_right[%0d] cyc %0d: got %0d/%0b want %0d/%0b", k, i, o_r[k], o_rv[k], m_right, m_vld); end
        checks++; if (longint'(w_o[k]) !== m_shadow || w_rdy[k] !== m_loaded) begin
          errors++; $display("FAIL rand_weight[%0d] cyc %0d: got %0d/%0b want %0d/%0b", k, i, w_o[k], w_rdy[k], m_shadow, m_loaded); end
        checks++; if (ovf_o[k] !== m_ovf[k]) begin
          errors++; $display("FAIL rand_ovf[%0d] cyc %0d: got %0b want %0b", k, i, ovf_o[k], m_ovf[k]); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_mac();
    test_swap_overlap();
    test_stall();
    test_overflow();
    test_unsigned();
    test_swap_empty();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
